// File: rtl/wifi_tx_pkg.sv
// Shared encodings for the Wi-Fi TX mapper controller: modulation codes,
// subcarrier count, bits-per-group table and FSM state encoding.
package wifi_tx_pkg;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_QAM16 = 2'd2;
    localparam logic [1:0] MOD_QAM64 = 2'd3;

    localparam int unsigned N_DATA_SC      = 48;
    localparam logic [5:0]  LAST_SC        = 6'(N_DATA_SC - 1);
    localparam int unsigned MAX_GROUP_BITS = 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_ISSUE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    function automatic logic [2:0] bits_per_mod(input logic [1:0] mod);
        logic [2:0] k;
        case (mod)
            MOD_BPSK:  k = 3'd1;
            MOD_QPSK:  k = 3'd2;
            MOD_QAM16: k = 3'd4;
            MOD_QAM64: k = 3'd6;
            default:   k = 3'd1;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/wifi_tx_mapper_ctrl_if.sv
// Bit-stream input and mapper-side output bundle of the TX mapper controller.
interface wifi_tx_mapper_ctrl_if;

    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       map_valid;
    logic [5:0] map_bits;
    logic [1:0] map_mod;
    logic [5:0] sc_idx;
    logic       sym_last;

    // master: the controller; slave: bit source plus mapper
    modport master (
        input  bit_valid, bit_in,
        output bit_ready, map_valid, map_bits, map_mod, sc_idx, sym_last
    );

    modport slave (
        output bit_valid, bit_in,
        input  bit_ready, map_valid, map_bits, map_mod, sc_idx, sym_last
    );

endinterface

// File: rtl/wifi_tx_bit_packer.sv
// Serial-to-parallel packer: shifts accepted bits in MSB-first and flags the
// bit that completes a k-bit group; group_bits is right-aligned, MSBs zero.
module wifi_tx_bit_packer
    import wifi_tx_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      accept,
    input  logic                      bit_in,
    input  logic [2:0]                k,
    output logic                      group_done,
    output logic [MAX_GROUP_BITS-1:0] group_bits
);

    logic [MAX_GROUP_BITS-2:0] shreg_r;
    logic [2:0]                cnt_r;

    // completing bit is taken straight from bit_in so the group is ready in the accept cycle
    always_comb begin
        group_done = accept && (cnt_r == (k - 3'd1));
        group_bits = {shreg_r, bit_in};
    end

    // shift register and group counter, emptied after every full group
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r <= '0;
            cnt_r   <= 3'd0;
        end else if (clr || group_done) begin
            shreg_r <= '0;
            cnt_r   <= 3'd0;
        end else if (accept) begin
            shreg_r <= {shreg_r[MAX_GROUP_BITS-3:0], bit_in};
            cnt_r   <= cnt_r + 3'd1;
        end
    end

endmodule

// File: rtl/wifi_tx_mapper_ctrl.sv
// Wi-Fi TX mapper controller: collects coded bits into constellation groups and
// strobes them to the mapper with subcarrier and symbol bookkeeping.
module wifi_tx_mapper_ctrl
    import wifi_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mod_sel,
    input  logic [7:0]            n_sym,
    wifi_tx_mapper_ctrl_if.master bus,
    output logic                  busy,
    output logic                  done
);

    logic [1:0]                state_r, state_s;
    logic [1:0]                mod_r;
    logic [7:0]                n_sym_r, sym_cnt_r;
    logic [5:0]                sc_cnt_r, sc_idx_r;
    logic [MAX_GROUP_BITS-1:0] map_bits_r, group_bits_s;
    logic                      bit_ready_r, map_valid_r, sym_last_r, busy_r, done_r;
    logic                      accept_s, group_done_s, last_issue_s, clr_s;
    logic [2:0]                k_s;

    assign accept_s     = bus.bit_valid & bit_ready_r;
    assign k_s          = bits_per_mod(mod_r);
    assign clr_s        = (state_r == ST_DONE);
    assign last_issue_s = (sc_cnt_r == LAST_SC) && (sym_cnt_r == (n_sym_r - 8'd1));

    wifi_tx_bit_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr_s),
        .accept     (accept_s),
        .bit_in     (bus.bit_in),
        .k          (k_s),
        .group_done (group_done_s),
        .group_bits (group_bits_s)
    );

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (n_sym == 8'd0) ? ST_DONE : ST_COLLECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (group_done_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_ISSUE: state_s = last_issue_s ? ST_DONE : ST_COLLECT;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // state and control outputs, registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            bit_ready_r <= 1'b0;
            map_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_ready_r <= (state_s == ST_COLLECT);
            map_valid_r <= (state_s == ST_ISSUE);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // frame parameters, mapper data and subcarrier/symbol counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mod_r      <= MOD_BPSK;
            n_sym_r    <= 8'd0;
            sc_cnt_r   <= 6'd0;
            sym_cnt_r  <= 8'd0;
            sc_idx_r   <= 6'd0;
            map_bits_r <= '0;
            sym_last_r <= 1'b0;
        end else begin
            sym_last_r <= 1'b0;
            if ((state_r == ST_IDLE) && start) begin
                mod_r   <= mod_sel;
                n_sym_r <= n_sym;
            end
            if ((state_r == ST_COLLECT) && group_done_s) begin
                map_bits_r <= group_bits_s;
                sc_idx_r   <= sc_cnt_r;
                sym_last_r <= (sc_cnt_r == LAST_SC);
            end
            if (state_r == ST_ISSUE) begin
                if (sc_cnt_r == LAST_SC) begin
                    sc_cnt_r  <= 6'd0;
                    sym_cnt_r <= sym_cnt_r + 8'd1;
                end else begin
                    sc_cnt_r  <= sc_cnt_r + 6'd1;
                end
            end
            if (state_r == ST_DONE) begin
                sc_cnt_r  <= 6'd0;
                sym_cnt_r <= 8'd0;
            end
        end
    end

    assign bus.bit_ready = bit_ready_r;
    assign bus.map_valid = map_valid_r;
    assign bus.map_bits  = map_bits_r;
    assign bus.map_mod   = mod_r;
    assign bus.sc_idx    = sc_idx_r;
    assign bus.sym_last  = sym_last_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_wifi_tx_mapper_ctrl.sv
// Directed self-checking bench for wifi_tx_mapper_ctrl.
module tb_wifi_tx_mapper_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mod_sel;
    logic [7:0] n_sym;
    logic       busy;
    logic       done;

    wifi_tx_mapper_ctrl_if bus ();

    wifi_tx_mapper_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mod_sel (mod_sel),
        .n_sym   (n_sym),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_mv     = 0;
    int n_done   = 0;
    int n_sl     = 0;
    int last_mv_cyc, prev_cyc, d0, mv0, sl0, wraps;
    logic [5:0] prev_sc, gval;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.map_valid === 1'b1) n_mv <= n_mv + 1;
        if (done === 1'b1)          n_done <= n_done + 1;
        if (bus.sym_last === 1'b1)  n_sl <= n_sl + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bit_ready"}, 32'(bus.bit_ready), 32'd0);
        check({tag, "_map_valid"}, 32'(bus.map_valid), 32'd0);
        check({tag, "_map_bits"},  32'(bus.map_bits),  32'd0);
        check({tag, "_map_mod"},   32'(bus.map_mod),   32'd0);
        check({tag, "_sc_idx"},    32'(bus.sc_idx),    32'd0);
        check({tag, "_sym_last"},  32'(bus.sym_last),  32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_done"},      32'(done),          32'd0);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] n);
        start   = 1'b1;
        mod_sel = m;
        n_sym   = n;
        tick();
        start   = 1'b0;
    endtask

    // offers one bit, waits (bounded) for bit_ready, and returns after the accepting edge
    task automatic push_bit(input logic b);
        int guard;
        guard = 0;
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        while (bus.bit_ready !== 1'b1 && guard < 16) begin
            tick();
            guard++;
        end
        check("bit_ready_wait", 32'(bus.bit_ready), 32'd1);
        check("no_early_map_valid", 32'(bus.map_valid), 32'd0);
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_group(input logic [5:0] val, input int k, input bit gap,
                              input logic [5:0] exp_sc, input logic exp_last);
        for (int j = k - 1; j >= 0; j--) begin
            if (gap) begin
                bus.bit_valid = 1'b0;
                tick();
            end
            push_bit(val[j]);
        end
        check("grp_map_valid", 32'(bus.map_valid), 32'd1);
        check("grp_map_bits",  32'(bus.map_bits),  32'(val));
        check("grp_sc_idx",    32'(bus.sc_idx),    32'(exp_sc));
        check("grp_sym_last",  32'(bus.sym_last),  32'(exp_last));
        last_mv_cyc = cyc;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mod_sel = 2'd0; n_sym = 8'd0;
        bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
        tick(); tick();
        check_zero("reset");
        reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // n_sym = 0: immediate done, no groups
        mv0 = n_mv; d0 = n_done;
        do_start(2'd1, 8'd0);
        check("nsym0_done",      32'(done),          32'd1);
        check("nsym0_bit_ready", 32'(bus.bit_ready), 32'd0);
        check("nsym0_map_valid", 32'(bus.map_valid), 32'd0);
        tick();
        check("nsym0_done_off",  32'(done),          32'd0);
        check("nsym0_busy_off",  32'(busy),          32'd0);
        check("nsym0_ready_off", 32'(bus.bit_ready), 32'd0);
        tick();
        check("nsym0_no_mv",     32'(n_mv - mv0),    32'd0);
        check("nsym0_one_done",  32'(n_done - d0),   32'd1);

        // 16QAM group packing, hold behaviour, start ignored while busy
        do_start(2'd2, 8'd1);
        check("qam16_busy",  32'(busy),          32'd1);
        check("qam16_ready", 32'(bus.bit_ready), 32'd1);
        send_group(6'b001011, 4, 1'b0, 6'd0, 1'b0);
        check("qam16_map_mod", 32'(bus.map_mod), 32'd2);
        tick();
        check("qam16_strobe_1cyc", 32'(bus.map_valid), 32'd0);
        check("qam16_bits_hold",   32'(bus.map_bits),  32'b001011);
        check("qam16_sc_hold",     32'(bus.sc_idx),    32'd0);
        send_group(6'b000110, 4, 1'b0, 6'd1, 1'b0);
        start = 1'b1; mod_sel = 2'd3; n_sym = 8'd0;
        tick();
        start = 1'b0;
        check("busy_start_busy", 32'(busy),        32'd1);
        check("busy_start_done", 32'(done),        32'd0);
        check("busy_start_mod",  32'(bus.map_mod), 32'd2);
        send_group(6'b001111, 4, 1'b0, 6'd2, 1'b0);
        reset = 1'b0;
        #1;
        check_zero("abort16");
        tick();
        reset = 1'b1;
        tick();

        // reset after 2 of 6 bits in 64QAM discards the partial group
        d0 = n_done;
        do_start(2'd3, 8'd1);
        push_bit(1'b1);
        push_bit(1'b1);
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        tick(); tick();
        check("mid_reset_no_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();
        check("mid_reset_done_cnt", 32'(n_done - d0), 32'd0);
        do_start(2'd3, 8'd1);
        send_group(6'b110010, 6, 1'b0, 6'd0, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // BPSK, one symbol, alternating bits
        d0 = n_done; sl0 = n_sl;
        do_start(2'd0, 8'd1);
        for (int i = 0; i < 48; i++) begin
            prev_cyc = last_mv_cyc;
            send_group((i % 2 == 0) ? 6'd1 : 6'd0, 1, 1'b0, 6'(i), (i == 47));
            if (i > 0) check("bpsk_spacing", 32'(last_mv_cyc - prev_cyc), 32'd2);
        end
        tick();
        check("bpsk_done", 32'(done), 32'd1);
        check("bpsk_busy", 32'(busy), 32'd1);
        tick();
        check("bpsk_done_off", 32'(done), 32'd0);
        check("bpsk_idle",     32'(busy), 32'd0);
        check("bpsk_sym_last_cnt", 32'(n_sl - sl0),   32'd1);
        check("bpsk_done_cnt",     32'(n_done - d0),  32'd1);

        // 64QAM, two symbols
        d0 = n_done; mv0 = n_mv; wraps = 0; prev_sc = 6'd0;
        do_start(2'd3, 8'd2);
        for (int g = 0; g < 96; g++) begin
            gval = 6'((g * 37 + 5) % 64);
            send_group(gval, 6, 1'b0, 6'(g % 48), ((g % 48) == 47));
            if (g > 0 && prev_sc == 6'd47 && bus.sc_idx == 6'd0) wraps++;
            prev_sc = bus.sc_idx;
        end
        tick();
        check("qam64_done", 32'(done), 32'd1);
        tick();
        check("qam64_mv_cnt",   32'(n_mv - mv0),  32'd96);
        check("qam64_wraps",    32'(wraps),       32'd1);
        check("qam64_done_cnt", 32'(n_done - d0), 32'd1);
        check("qam64_idle",     32'(busy),        32'd0);

        // QPSK with bit_valid gaps, extra start mid-frame ignored
        d0 = n_done;
        do_start(2'd1, 8'd1);
        for (int g = 0; g < 48; g++) begin
            gval = 6'((g * 3 + 1) % 4);
            send_group(gval, 2, 1'b1, 6'(g), (g == 47));
            if (g == 10) begin
                start = 1'b1; mod_sel = 2'd0; n_sym = 8'd5;
                tick();
                start = 1'b0;
                check("qpsk_ignore_mod",  32'(bus.map_mod), 32'd1);
                check("qpsk_ignore_busy", 32'(busy),        32'd1);
            end
        end
        tick();
        check("qpsk_done", 32'(done), 32'd1);
        tick();
        check("qpsk_done_cnt", 32'(n_done - d0), 32'd1);
        check("qpsk_idle",     32'(busy),        32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
